// File: rtl/regfile_sb.sv
// 2-read/2-write register file with scoreboard busy bits and a
// bulk-clear sequencer. Ports: clk, rst (async, active-low), two
// write ports (weX/addr_wrX/data_wrX, port 1 wins), two combinational
// reads (rs1/rs2 + busy), issue handshake (iss_valid/iss_addr/
// iss_ready), clear control (clr_start/clr_busy).
module regfile_sb #(
  parameter int N        = 3,
  parameter int W        = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we0,
  input  logic [N-1:0] addr_wr0,
  input  logic [W-1:0] data_wr0,
  input  logic         we1,
  input  logic [N-1:0] addr_wr1,
  input  logic [W-1:0] data_wr1,
  input  logic [N-1:0] addr_rs1,
  input  logic [N-1:0] addr_rs2,
  output logic [W-1:0] rs1,
  output logic [W-1:0] rs2,
  output logic         rs1_busy,
  output logic         rs2_busy,
  input  logic         iss_valid,
  input  logic [N-1:0] iss_addr,
  output logic         iss_ready,
  input  logic         clr_start,
  output logic         clr_busy
);

  localparam int R = 1 << N;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   cnt_q;
  logic [N-1:0]   cnt_d;
  logic [W-1:0]   regs_q [R];
  logic [R-1:0]   busy_q;
  logic [R-1:0]   busy_d;

  logic idle;
  logic wr0_en;
  logic wr1_en;
  logic iss_go;

  // r0 is treated as unwritable and never busy when hardwired
  function automatic logic live(input logic [N-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign idle   = (state_q == IDLE);
  assign wr0_en = we0 && idle && live(addr_wr0);
  assign wr1_en = we1 && idle && live(addr_wr1);

  // no busy bypass: a same-cycle write does not make iss_addr ready
  assign iss_ready = idle && !busy_q[iss_addr];
  assign iss_go    = iss_valid && iss_ready && live(iss_addr);

  always_comb begin
    rs1 = regs_q[addr_rs1];
    if (BYPASS != 0 && wr1_en && addr_wr1 == addr_rs1)
      rs1 = data_wr1;
    else if (BYPASS != 0 && wr0_en && addr_wr0 == addr_rs1)
      rs1 = data_wr0;
    if (!live(addr_rs1))
      rs1 = '0;
  end

  always_comb begin
    rs2 = regs_q[addr_rs2];
    if (BYPASS != 0 && wr1_en && addr_wr1 == addr_rs2)
      rs2 = data_wr1;
    else if (BYPASS != 0 && wr0_en && addr_wr0 == addr_rs2)
      rs2 = data_wr0;
    if (!live(addr_rs2))
      rs2 = '0;
  end

  assign rs1_busy = busy_q[addr_rs1]
    && !(wr0_en && addr_wr0 == addr_rs1)
    && !(wr1_en && addr_wr1 == addr_rs1);

  assign rs2_busy = busy_q[addr_rs2]
    && !(wr0_en && addr_wr0 == addr_rs2)
    && !(wr1_en && addr_wr1 == addr_rs2);

  // issue set is applied last so it wins over a same-cycle write
  always_comb begin
    busy_d = busy_q;
    if (state_q == CLEAR) begin
      busy_d[cnt_q] = 1'b0;
    end else begin
      if (wr0_en) busy_d[addr_wr0] = 1'b0;
      if (wr1_en) busy_d[addr_wr1] = 1'b0;
      if (iss_go) busy_d[iss_addr] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        clr_busy = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == N'(R - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // port 1 is written last so it wins on an address collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < R; i++)
        regs_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      regs_q[cnt_q] <= '0;
    end else begin
      if (wr0_en) regs_q[addr_wr0] <= data_wr0;
      if (wr1_en) regs_q[addr_wr1] <= data_wr1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed + model-checked bench for regfile_sb.
// Runs a BYPASS=1 and a BYPASS=0 instance on shared stimulus.
module tb_regfile_sb;

  logic       clk;
  logic       rst;
  logic       we0;
  logic [2:0] addr_wr0;
  logic [7:0] data_wr0;
  logic       we1;
  logic [2:0] addr_wr1;
  logic [7:0] data_wr1;
  logic [2:0] addr_rs1;
  logic [2:0] addr_rs2;
  logic       iss_valid;
  logic [2:0] iss_addr;
  logic       clr_start;

  logic [7:0] rs1, rs2, nb_rs1, nb_rs2;
  logic       rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  logic       iss_ready, nb_iss_ready;
  logic       clr_busy, nb_clr_busy;

  int checks;
  int failures;

  logic [7:0] m_reg [8];
  logic [7:0] m_busy;
  logic [7:0] fillv [8];

  regfile_sb #(.N(3), .W(8), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .addr_wr0(addr_wr0), .data_wr0(data_wr0),
    .we1(we1), .addr_wr1(addr_wr1), .data_wr1(data_wr1),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready),
    .clr_start(clr_start), .clr_busy(clr_busy)
  );

  regfile_sb #(.N(3), .W(8), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .we0(we0), .addr_wr0(addr_wr0), .data_wr0(data_wr0),
    .we1(we1), .addr_wr1(addr_wr1), .data_wr1(data_wr1),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1(nb_rs1), .rs2(nb_rs2),
    .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(nb_iss_ready),
    .clr_start(clr_start), .clr_busy(nb_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 0; we1 = 0; iss_valid = 0; clr_start = 0;
    addr_wr0 = 0; addr_wr1 = 0; data_wr0 = 0; data_wr1 = 0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_busy = 0;
  endtask

  function automatic logic [7:0] e_rd(input logic [2:0] a,
                                      input logic byp);
    if (a == 0) return 0;
    if (byp && we1 && addr_wr1 == a) return data_wr1;
    if (byp && we0 && addr_wr0 == a) return data_wr0;
    return m_reg[a];
  endfunction

  function automatic logic e_busy(input logic [2:0] a);
    if (a == 0) return 0;
    if (we0 && addr_wr0 == a) return 0;
    if (we1 && addr_wr1 == a) return 0;
    return m_busy[a];
  endfunction

  initial begin
    logic rdy;
    checks = 0;
    failures = 0;
    m_clear();
    idle_in();
    addr_rs1 = 0; addr_rs2 = 0; iss_addr = 0;
    rst = 0;
    #3;
    check("rst_rs1", 32'(rs1), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_iss_ready", 32'(iss_ready), 1);
    #9 rst = 1;
    cyc();

    // port collision and bypass
    we0 = 1; addr_wr0 = 3; data_wr0 = 8'h11; addr_rs1 = 3;
    cyc();
    we0 = 1; addr_wr0 = 3; data_wr0 = 8'h5A;
    we1 = 1; addr_wr1 = 3; data_wr1 = 8'hA5;
    @(negedge clk);
    check("byp_same_cyc", 32'(rs1), 'hA5);
    check("nobyp_same_cyc", 32'(nb_rs1), 'h11);
    cyc();
    idle_in();
    @(negedge clk);
    check("byp_next", 32'(rs1), 'hA5);
    check("nobyp_next", 32'(nb_rs1), 'hA5);

    // hardwired r0
    cyc();
    we0 = 1; addr_wr0 = 0; data_wr0 = 8'hFF;
    iss_valid = 1; iss_addr = 0; addr_rs1 = 0;
    @(negedge clk);
    check("r0_byp", 32'(rs1), 0);
    check("r0_ready", 32'(iss_ready), 1);
    cyc();
    idle_in();
    @(negedge clk);
    check("r0_rd", 32'(rs1), 0);
    check("r0_busy", 32'(rs1_busy), 0);
    check("r0_ready2", 32'(iss_ready), 1);

    // scoreboard on r5
    cyc();
    iss_valid = 1; iss_addr = 5; addr_rs2 = 5;
    @(negedge clk);
    check("r5_ready_pre", 32'(iss_ready), 1);
    cyc();
    iss_valid = 0;
    @(negedge clk);
    check("r5_ready_busy", 32'(iss_ready), 0);
    check("r5_rs2_busy", 32'(rs2_busy), 1);
    cyc();
    we0 = 1; addr_wr0 = 5; data_wr0 = 8'h33;
    @(negedge clk);
    check("r5_busy_wcyc", 32'(rs2_busy), 0);
    check("r5_ready_nobyp", 32'(iss_ready), 0);
    cyc();
    idle_in();
    @(negedge clk);
    check("r5_data", 32'(rs2), 'h33);
    check("r5_ready_post", 32'(iss_ready), 1);

    // issue and write to same idle reg: set wins
    cyc();
    iss_valid = 1; iss_addr = 6;
    we0 = 1; addr_wr0 = 6; data_wr0 = 8'h66; addr_rs1 = 6;
    cyc();
    idle_in();
    @(negedge clk);
    check("set_wins", 32'(rs1_busy), 1);
    check("set_wins_data", 32'(rs1), 'h66);

    // bulk clear
    for (int i = 1; i < 8; i++) begin
      cyc();
      fillv[i] = 8'(i * 37 + 5);
      we0 = 1; addr_wr0 = 3'(i); data_wr0 = fillv[i];
    end
    cyc();
    idle_in();
    iss_valid = 1; iss_addr = 2;
    cyc();
    idle_in();
    clr_start = 1;
    addr_rs1 = 7;
    @(negedge clk);
    check("clr_pre", 32'(clr_busy), 0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      clr_start = (c == 3);
      we0 = 1; addr_wr0 = 7; data_wr0 = 8'hEE;
      we1 = 1; addr_wr1 = 1; data_wr1 = 8'hDD;
      iss_valid = 1; iss_addr = 4;
      @(negedge clk);
      check("clr_active", 32'(clr_busy), 1);
      check("clr_noiss", 32'(iss_ready), 0);
      if (c == 0) check("clr_rd_stored", 32'(rs1), 32'(fillv[7]));
    end
    cyc();
    idle_in();
    @(negedge clk);
    check("clr_done", 32'(clr_busy), 0);
    check("clr_ready", 32'(iss_ready), 1);
    for (int i = 0; i < 8; i++) begin
      addr_rs1 = 3'(i); addr_rs2 = 3'(7 - i);
      #1;
      check("clr_rs1", 32'(rs1), 0);
      check("clr_rs1_busy", 32'(rs1_busy), 0);
      check("clr_rs2_busy", 32'(rs2_busy), 0);
    end

    // async reset in the middle of a clear with traffic
    cyc();
    we0 = 1; addr_wr0 = 4; data_wr0 = 8'h44;
    iss_valid = 1; iss_addr = 4;
    cyc();
    idle_in();
    clr_start = 1;
    cyc();
    clr_start = 0;
    cyc();
    addr_rs1 = 4; addr_rs2 = 4; iss_addr = 4;
    #2 rst = 0;
    #1;
    check("mrst_rs1", 32'(rs1), 0);
    check("mrst_busy", 32'(rs2_busy), 0);
    check("mrst_ready", 32'(iss_ready), 1);
    check("mrst_clr", 32'(clr_busy), 0);
    #3 rst = 1;
    m_clear();

    // random traffic against the model
    for (int n = 0; n < 1000; n++) begin
      cyc();
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 2) == 0);
      addr_wr0 = 3'($urandom); data_wr0 = 8'($urandom);
      addr_wr1 = 3'($urandom); data_wr1 = 8'($urandom);
      addr_rs1 = 3'($urandom); addr_rs2 = 3'($urandom);
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr = 3'($urandom);
      @(negedge clk);
      rdy = !m_busy[iss_addr];
      check("rnd_rs1", 32'(rs1), 32'(e_rd(addr_rs1, 1)));
      check("rnd_rs2", 32'(rs2), 32'(e_rd(addr_rs2, 1)));
      check("rnd_nb_rs1", 32'(nb_rs1), 32'(e_rd(addr_rs1, 0)));
      check("rnd_b1", 32'(rs1_busy), 32'(e_busy(addr_rs1)));
      check("rnd_b2", 32'(rs2_busy), 32'(e_busy(addr_rs2)));
      check("rnd_rdy", 32'(iss_ready), 32'(rdy));
      if (we0 && addr_wr0 != 0) begin
        m_reg[addr_wr0] = data_wr0;
        m_busy[addr_wr0] = 0;
      end
      if (we1 && addr_wr1 != 0) begin
        m_reg[addr_wr1] = data_wr1;
        m_busy[addr_wr1] = 0;
      end
      if (iss_valid && rdy && iss_addr != 0)
        m_busy[iss_addr] = 1;
    end
    cyc();
    idle_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
